// File: rtl/johnson_monitor.sv
// johnson_monitor: Johnson code decoder and sequence checker with saturating error count and sticky alarm; `JOHNSON_MON_STALL_EN` accepts repeated indices
module johnson_monitor #(
  parameter int WIDTH        = 4,
  parameter int ERR_W        = 8,
  parameter int ALARM_THRESH = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           counter_state,
  output logic [$clog2(2*WIDTH)-1:0] count,
  output logic                       count_valid,
  output logic                       illegal_state,
  output logic                       seq_error,
  output logic [ERR_W-1:0]           err_count,
  output logic                       locked,
  output logic                       alarm
);
  localparam int CW = $clog2(2*WIDTH);
  localparam int N  = 2*WIDTH;
  typedef enum logic [1:0] {UNLOCKED, LOCKED, ALARM} state_t;
  state_t           state_q, state_d;
  logic             track_q, track_d;
  logic [CW-1:0]    count_q, count_d, idx, succ;
  logic             cv_q, cv_d, ill_q, ill_d, seq_q, seq_d, locked_q, locked_d, alarm_q, alarm_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] x;
  logic [CW:0]      pop;
  logic             legal, stall_ok, ill, seq_bad, raise;
  // Folding the MSB=1 half onto the MSB=0 half leaves one shape to test: 0..01..1
  always_comb begin
    x = counter_state[WIDTH-1] ? ~counter_state : counter_state;
    legal = (x & (x + 1'b1)) == '0;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + (CW+1)'(counter_state[i]);
    idx = counter_state[WIDTH-1] ? CW'(N - int'(pop)) : CW'(pop);
    succ = count_q == CW'(N-1) ? '0 : count_q + CW'(1);
  end
`ifdef JOHNSON_MON_STALL_EN
  assign stall_ok = idx == count_q;
`else
  assign stall_ok = 1'b0;
`endif
  // track_q: a previous index exists to check against, kept separately so ALARM still checks sequence
  always_comb begin
    ill = in_valid && !legal;
    seq_bad = in_valid && legal && track_q && !(idx == succ || idx == '0 || stall_ok);
    err_d = (ill || seq_bad) && err_q != '1 ? err_q + 1'b1 : err_q;
    raise = (ill || seq_bad) && err_d >= ERR_W'(ALARM_THRESH);
    track_d = in_valid ? legal : track_q;
    state_d = state_q == ALARM || raise ? ALARM : track_d ? LOCKED : UNLOCKED;
  end
  always_comb begin
    count_d = in_valid && legal ? idx : count_q;
    cv_d = in_valid && legal;
    ill_d = ill;
    seq_d = seq_bad;
    locked_d = state_d != UNLOCKED;
    alarm_d = state_d == ALARM;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= UNLOCKED;
      track_q <= 1'b0;
      count_q <= '0;
      cv_q <= 1'b0;
      ill_q <= 1'b0;
      seq_q <= 1'b0;
      err_q <= '0;
      locked_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      track_q <= track_d;
      count_q <= count_d;
      cv_q <= cv_d;
      ill_q <= ill_d;
      seq_q <= seq_d;
      err_q <= err_d;
      locked_q <= locked_d;
      alarm_q <= alarm_d;
    end
  end
  assign count = count_q;
  assign count_valid = cv_q;
  assign illegal_state = ill_q;
  assign seq_error = seq_q;
  assign err_count = err_q;
  assign locked = locked_q;
  assign alarm = alarm_q;
endmodule

// File: tb/tb_johnson_monitor.sv
// tb_johnson_monitor: directed stimulus checked each cycle against a table-driven behavioural model plus literal pins
module tb_johnson_monitor;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] counter_state = '0;
  logic [2:0] count;
  logic       count_valid, illegal_state, seq_error, locked, alarm;
  logic [7:0] err_count;

  johnson_monitor #(.WIDTH(4), .ERR_W(8), .ALARM_THRESH(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .counter_state(counter_state),
    .count(count), .count_valid(count_valid), .illegal_state(illegal_state),
    .seq_error(seq_error), .err_count(err_count), .locked(locked), .alarm(alarm)
  );

  always #5 clock = ~clock;

`ifdef JOHNSON_MON_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  int n_cmp, n_fail;
  int m_prev, m_err, e_count;
  bit m_have, m_alarm, e_cv, e_ill, e_seq;

  // Legal words are generated by enumerating the 2*WIDTH steps of the Johnson sequence
  function automatic int code_index(input logic [3:0] c);
    for (int k = 0; k < 8; k++) begin
      int code;
      code = k <= 4 ? (1 << k) - 1 : 15 ^ ((1 << (k - 4)) - 1);
      if (c == 4'(code)) return k;
    end
    return -1;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_have = 0; m_err = 0; m_alarm = 0;
    e_count = 0; e_cv = 0; e_ill = 0; e_seq = 0;
  endtask

  task automatic bump();
    if (m_err < 255) m_err++;
    if (m_err >= 3) m_alarm = 1;
  endtask

  task automatic model(input bit v, input logic [3:0] c);
    int k;
    e_cv = 0; e_ill = 0; e_seq = 0;
    if (v) begin
      k = code_index(c);
      if (k < 0) begin
        e_ill = 1; bump(); m_have = 0;
      end else begin
        e_cv = 1; e_count = k;
        if (m_have && k != (m_prev + 1) % 8 && k != 0 && !(STALL && k == m_prev)) begin
          e_seq = 1; bump();
        end
        m_prev = k; m_have = 1;
      end
    end
  endtask

  task automatic compare_all();
    cmp("count", int'(count), e_count);
    cmp("count_valid", int'(count_valid), int'(e_cv));
    cmp("illegal_state", int'(illegal_state), int'(e_ill));
    cmp("seq_error", int'(seq_error), int'(e_seq));
    cmp("err_count", int'(err_count), m_err);
    cmp("locked", int'(locked), int'(m_alarm || m_have));
    cmp("alarm", int'(alarm), int'(m_alarm));
  endtask

  task automatic step(input bit v, input logic [3:0] c);
    in_valid = v; counter_state = c;
    @(posedge clock);
    model(v, c);
    @(negedge clock);
    compare_all();
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
  endtask

  logic [3:0] clean [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    n_cmp = 0; n_fail = 0;
    model_reset();
    @(negedge clock);
    apply_reset();
    cmp("pin_reset_locked", int'(locked), 0);
    cmp("pin_reset_count", int'(count), 0);

    foreach (clean[i]) begin
      step(1'b1, clean[i]);
      if (i == 4) cmp("pin_clean_mid_count", int'(count), 4);
    end
    cmp("pin_clean_count", int'(count), 0);
    cmp("pin_clean_err", int'(err_count), 0);
    cmp("pin_clean_locked", int'(locked), 1);

    step(1'b1, 4'b0101);
    cmp("pin_illegal_pulse", int'(illegal_state), 1);
    cmp("pin_illegal_locked", int'(locked), 0);
    step(1'b1, 4'b0011);
    cmp("pin_relock_count", int'(count), 2);
    cmp("pin_relock_seq", int'(seq_error), 0);
    step(1'b0, 4'b0101);
    cmp("pin_idle_count", int'(count), 2);
    step(1'b1, 4'b0111);

    apply_reset();
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0111);
    cmp("pin_skip_seq", int'(seq_error), 1);
    cmp("pin_skip_count", int'(count), 3);
    step(1'b1, 4'b1111);
    step(1'b1, 4'b0000);
    cmp("pin_resync_err", int'(err_count), 1);
    step(1'b0, 4'b1111);

    apply_reset();
    step(1'b1, 4'b0101);
    step(1'b1, 4'b1010);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b1111);
    cmp("pin_alarm_rise", int'(alarm), 1);
    cmp("pin_alarm_err", int'(err_count), 3);
    step(1'b1, 4'b1110);
    step(1'b1, 4'b1100);
    step(1'b1, 4'b1000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0101);
    cmp("pin_alarm_locked", int'(locked), 1);
    for (int i = 0; i < 260; i++) step(1'b1, 4'b1011);
    cmp("pin_sat_err", int'(err_count), 255);
    cmp("pin_sat_pulse", int'(illegal_state), 1);
    step(1'b1, 4'b0000);
    apply_reset();
    cmp("pin_alarm_cleared", int'(alarm), 0);

    step(1'b1, 4'b0011);
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0111);
    cmp("pin_stall_err", int'(err_count), STALL ? 0 : 1);

    apply_reset();
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0111);
    step(1'b1, 4'b0101);
    step(1'b1, 4'b0001);
    cmp("pin_pre_async_err", int'(err_count), 2);
    #2 reset = 1'b1; in_valid = 1'b0;
    #1;
    cmp("async_count", int'(count), 0);
    cmp("async_err", int'(err_count), 0);
    cmp("async_locked", int'(locked), 0);
    cmp("async_alarm", int'(alarm), 0);
    cmp("async_flags", int'({count_valid, illegal_state, seq_error}), 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    step(1'b1, 4'b1100);
    cmp("pin_post_async_6", int'(count), 6);
    step(1'b1, 4'b1000);
    cmp("pin_post_async_7", int'(count), 7);
    cmp("pin_post_async_err", int'(err_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
